// File: rtl/display_pkg.sv
// display_pkg: shared constants and state type for the seven-segment
// display controller (controlador_display) and its BCD adjust cell.
package display_pkg;

  // Digits held by the double-dabble accumulator (enough for 2^32-1).
  localparam int N_BCD       = 10;
  // One shift step per input bit.
  localparam int CICLOS_CONV = 32;
  // Bits per BCD digit.
  localparam int LARG_DIG    = 4;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    PUBLICA  = 2'd2
  } estado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// ajuste_bcd: combinational single-digit double-dabble correction.
// A digit >= 5 gets +3 so that the following left shift carries
// correctly into the next decimal digit.
//   dig_in  : BCD digit before the shift step
//   dig_out : corrected digit
module ajuste_bcd
  import display_pkg::*;
(
  input  logic [LARG_DIG-1:0] dig_in,
  output logic [LARG_DIG-1:0] dig_out
);

  assign dig_out = (dig_in >= 4'd5) ? dig_in + 4'd3 : dig_in;

endmodule

// File: rtl/controlador_display.sv
// controlador_display: arbitrates the CPU and debug display requesters
// (CPU has fixed priority), converts the accepted 32-bit word to BCD with
// an iterative double-dabble engine (one bit per clock) and holds the
// result for the sete_segmentos instances.
//
// Optional feature: define SINAL_DISPLAY_EN to treat the accepted word as
// two's complement; its magnitude is converted and `negativo` shows the
// sign. Without it the word is unsigned and `negativo` is tied to 0.
//
// Ports:
//   clock, reset          : clock, async active-low reset
//   req_cpu/dado_cpu      : CPU request (held until ack_cpu) and value
//   req_dbg/dado_dbg      : debug request (held until ack_dbg) and value
//   ack_cpu/ack_dbg       : one-cycle acceptance pulses
//   bcd                   : held digits, [3:0] = units
//   controle              : display enable, set after the first result
//   ocupado               : conversion in progress
//   estouro               : value above 99,999,999 (bcd = low 8 digits)
//   negativo              : sign of displayed value
module controlador_display
  import display_pkg::*;
#(
  parameter int LARGURA = 32,
  parameter int DIGITOS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_cpu,
  input  logic [LARGURA-1:0]    dado_cpu,
  input  logic                  req_dbg,
  input  logic [LARGURA-1:0]    dado_dbg,
  output logic                  ack_cpu,
  output logic                  ack_dbg,
  output logic [4*DIGITOS-1:0]  bcd,
  output logic                  controle,
  output logic                  ocupado,
  output logic                  estouro,
  output logic                  negativo
);

  localparam int ACC_W = LARG_DIG * N_BCD;
  localparam int CNT_W = $clog2(CICLOS_CONV);
  localparam logic [CNT_W-1:0] ULT_PASSO = CNT_W'(CICLOS_CONV - 1);

  estado_t            estado, estado_prox;
  logic [CNT_W-1:0]   cont;
  logic [ACC_W-1:0]   acc, acc_aj;
  logic [LARGURA-1:0] desloc;

  logic aceita_cpu, aceita_dbg, carrega, passo, publica;
  logic [LARGURA-1:0] palavra_sel, magnitude;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (req_cpu || req_dbg) estado_prox = CONVERTE;
      CONVERTE: if (cont == ULT_PASSO)  estado_prox = PUBLICA;
      PUBLICA:  estado_prox = OCIOSO;
      default:  estado_prox = OCIOSO;
    endcase
  end

  // ---------------- FSM: outputs / datapath strobes ----------------
  always_comb begin
    aceita_cpu = 1'b0;
    aceita_dbg = 1'b0;
    passo      = 1'b0;
    publica    = 1'b0;
    ocupado    = 1'b1;
    case (estado)
      OCIOSO: begin
        ocupado    = 1'b0;
        aceita_cpu = req_cpu;
        aceita_dbg = !req_cpu && req_dbg;
      end
      CONVERTE: passo   = 1'b1;
      PUBLICA:  publica = 1'b1;
      default:  ocupado = 1'b0;
    endcase
  end

  assign carrega     = aceita_cpu || aceita_dbg;
  assign palavra_sel = aceita_cpu ? dado_cpu : dado_dbg;

`ifdef SINAL_DISPLAY_EN
  // Magnitude taken at acceptance; 0x80000000 maps to 2^31 unsigned.
  assign magnitude = palavra_sel[LARGURA-1] ? (~palavra_sel + 1'b1) : palavra_sel;
`else
  assign magnitude = palavra_sel;
`endif

  // ---------------- add-3 on every accumulator digit ----------------
  for (genvar d = 0; d < N_BCD; d++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .dig_in  (acc   [d*LARG_DIG +: LARG_DIG]),
      .dig_out (acc_aj[d*LARG_DIG +: LARG_DIG])
    );
  end

  // ---------------- conversion engine ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont   <= '0;
      acc    <= '0;
      desloc <= '0;
    end else if (carrega) begin
      cont   <= '0;
      acc    <= '0;
      desloc <= magnitude;
    end else if (passo) begin
      // {acc, desloc} shifted left as one register after the adjust.
      acc    <= {acc_aj[ACC_W-2:0], desloc[LARGURA-1]};
      desloc <= {desloc[LARGURA-2:0], 1'b0};
      cont   <= cont + 1'b1;
    end
  end

  // ---------------- handshake and published result ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_cpu  <= 1'b0;
      ack_dbg  <= 1'b0;
      bcd      <= '0;
      estouro  <= 1'b0;
      controle <= 1'b0;
    end else begin
      ack_cpu <= aceita_cpu;
      ack_dbg <= aceita_dbg;
      if (publica) begin
        bcd      <= acc[4*DIGITOS-1:0];
        estouro  <= |acc[ACC_W-1:4*DIGITOS];
        controle <= 1'b1;
      end
    end
  end

`ifdef SINAL_DISPLAY_EN
  logic sinal_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinal_q  <= 1'b0;
      negativo <= 1'b0;
    end else begin
      if (carrega) sinal_q  <= palavra_sel[LARGURA-1];
      if (publica) negativo <= sinal_q;
    end
  end
`else
  assign negativo = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_display.sv
// tb_controlador_display: directed vectors with hand-computed expectations
// for controlador_display (handshake, priority, latency, boundaries,
// mid-conversion reset, sign option).
module tb_controlador_display;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_cpu = 1'b0, req_dbg = 1'b0;
  logic [31:0] dado_cpu = '0, dado_dbg = '0;
  logic        ack_cpu, ack_dbg, controle, ocupado, estouro, negativo;
  logic [31:0] bcd;

  int n_cmp = 0;
  int n_err = 0;

  controlador_display dut (
    .clock    (clock),
    .reset    (reset),
    .req_cpu  (req_cpu),
    .dado_cpu (dado_cpu),
    .req_dbg  (req_dbg),
    .dado_dbg (dado_dbg),
    .ack_cpu  (ack_cpu),
    .ack_dbg  (ack_dbg),
    .bcd      (bcd),
    .controle (controle),
    .ocupado  (ocupado),
    .estouro  (estouro),
    .negativo (negativo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise a request on the falling edge.
  task automatic start_req(input bit dbg, input logic [31:0] d);
    @(negedge clock);
    if (dbg) begin req_dbg = 1'b1; dado_dbg = d; end
    else     begin req_cpu = 1'b1; dado_cpu = d; end
  endtask

  // Wait for the ack pulse (sampled 1 time unit after the edge), then drop req.
  task automatic wait_ack(input bit dbg);
    bit got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (dbg ? ack_dbg : ack_cpu) begin got = 1; break; end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    if (dbg) req_dbg = 1'b0; else req_cpu = 1'b0;
  endtask

  // Count busy cycles until ocupado drops; also counts any ack pulses seen.
  task automatic wait_done(input int busy0, output int busy, output int acks);
    bit done = 0;
    busy = busy0;
    acks = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (ack_cpu || ack_dbg) acks++;
      if (!ocupado) begin done = 1; break; end
      busy++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic convert(input bit dbg, input logic [31:0] d, output int busy);
    int acks;
    start_req(dbg, d);
    wait_ack(dbg);
    wait_done(1, busy, acks);
  endtask

  logic [31:0] bnd_in  [3] = '{32'h05F5E0FF, 32'h05F5E100, 32'hFFFFFFFF};
  logic [31:0] bnd_bcd [3] = '{32'h99999999, 32'h00000000, 32'h94967295};
  logic        bnd_ovf [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    int busy, acks;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_bcd",      bcd,      32'd0);
    chk("rst_controle", controle, 32'd0);
    chk("rst_ocupado",  ocupado,  32'd0);
    chk("rst_ack",      {ack_cpu, ack_dbg}, 32'd0);
    chk("rst_estouro",  estouro,  32'd0);
    reset = 1'b1;

    // Basic CPU request: 1234 decimal.
    start_req(0, 32'h000004D2);
    wait_ack(0);
    chk("basic_ocupado_at_ack", ocupado, 32'd1);
    wait_done(1, busy, acks);
    chk("basic_busy_cycles", busy, 32'd33);
    chk("basic_ack_pulse_once", acks, 32'd0);
    chk("basic_bcd", bcd, 32'h00001234);
    chk("basic_controle", controle, 32'd1);
    chk("basic_estouro", estouro, 32'd0);

    // Simultaneous requests: CPU first, debug accepted at E34.
    @(negedge clock);
    req_cpu = 1'b1; dado_cpu = 32'd5;
    req_dbg = 1'b1; dado_dbg = 32'd7;
    @(posedge clock); #1;
    chk("simul_ack_cpu", ack_cpu, 32'd1);
    chk("simul_no_ack_dbg", ack_dbg, 32'd0);
    req_cpu = 1'b0;
    wait_done(1, busy, acks);
    chk("simul_no_ack_during", acks, 32'd0);
    chk("simul_bcd_cpu", bcd, 32'h00000005);
    @(posedge clock); #1;
    chk("simul_ack_dbg_e34", ack_dbg, 32'd1);
    req_dbg = 1'b0;
    wait_done(1, busy, acks);
    chk("simul_bcd_dbg", bcd, 32'h00000007);

    // Boundaries.
    for (int i = 0; i < 3; i++) begin
      convert(i[0], bnd_in[i], busy);
      chk($sformatf("bnd%0d_bcd", i), bcd, bnd_bcd[i]);
      chk($sformatf("bnd%0d_estouro", i), estouro, {31'd0, bnd_ovf[i]});
    end

    // Reset mid-conversion (display currently shows 94967295).
    start_req(0, 32'h00012345);
    wait_ack(0);
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_bcd", bcd, 32'd0);
    chk("midrst_controle", controle, 32'd0);
    chk("midrst_ocupado", ocupado, 32'd0);
    chk("midrst_ack", {ack_cpu, ack_dbg}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    convert(0, 32'd42, busy);
    chk("postrst_busy", busy, 32'd33);
    chk("postrst_bcd", bcd, 32'h00000042);

    // Debug request raised during a CPU conversion.
    start_req(0, 32'd11);
    wait_ack(0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    req_dbg = 1'b1; dado_dbg = 32'd99;
    wait_done(7, busy, acks);
    chk("during_no_ack_dbg", acks, 32'd0);
    chk("during_bcd_cpu", bcd, 32'h00000011);
    @(posedge clock); #1;
    chk("during_ack_dbg", ack_dbg, 32'd1);
    req_dbg = 1'b0;
    @(posedge clock); #1;
    chk("during_ack_dbg_one_cycle", ack_dbg, 32'd0);
    wait_done(2, busy, acks);
    chk("during_bcd_dbg", bcd, 32'h00000099);

    // Sign option, input 0xFFFFFFFF.
    convert(0, 32'hFFFFFFFF, busy);
`ifdef SINAL_DISPLAY_EN
    chk("sign_bcd", bcd, 32'h00000001);
    chk("sign_negativo", negativo, 32'd1);
`else
    chk("sign_bcd", bcd, 32'h94967295);
    chk("sign_negativo", negativo, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_display.md
Name: controlador_display

Overview:
- Sequences the 8-digit seven-segment output path.
- Arbitrates two 32-bit requesters: the CPU OUTPUT instruction and the debug monitor.
- Converts the accepted binary word to BCD with an iterative double-dabble (shift-add-3) engine and holds the result in registers.
- Drives the BCD nibbles and the display `controle` enable consumed by the `sete_segmentos` instances.

Parameters:
- LARGURA, 32, width of the binary input words. Only the default is supported.
- DIGITOS, 8, number of BCD digits published on `bcd`. Must be ≤ N_BCD.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_cpu  in  1  CPU requests display; held high until ack_cpu.
- dado_cpu  in  LARGURA  CPU value; stable while req_cpu is high.
- req_dbg  in  1  debug requests display; held high until ack_dbg.
- dado_dbg  in  LARGURA  debug value; stable while req_dbg is high.
- ack_cpu  out  1  one-cycle pulse: CPU request accepted.
- ack_dbg  out  1  one-cycle pulse: debug request accepted.
- bcd  out  4*DIGITOS  held digits; [3:0] = unidade, [31:28] = d_milhao.
- controle  out  1  display enable; 1 once a valid result has been published.
- ocupado  out  1  conversion in progress.
- estouro  out  1  value exceeds 99,999,999; bcd then holds the low 8 decimal digits.
- negativo  out  1  sign of the displayed value (see Optional Feature).

Behaviour:
- Reset (reset = 0, asynchronous): all outputs 0; FSM = OCIOSO; counter and shift registers cleared.
  - A reset mid-conversion aborts it; the previous result is lost.
- FSM states: OCIOSO, CONVERTE, PUBLICA.
- OCIOSO, clock edge E0:
  - req_cpu = 1 wins: load dado_cpu, ack_cpu = 1 for the cycle after E0.
  - Else req_dbg = 1: load dado_dbg, ack_dbg = 1 for the cycle after E0.
  - Fixed priority, CPU first; simultaneous requests give CPU first, debug stays pending.
  - On acceptance: counter = 0, 40-bit BCD accumulator (N_BCD = 10 digits) = 0, go to CONVERTE, ocupado = 1.
- CONVERTE, edges E1..E32: one step per edge.
  - Every accumulator digit ≥ 5 gets +3.
  - Then {acc, shift} shifts left by 1.
  - Counter increments; at counter = 31 go to PUBLICA.
- PUBLICA, edge E33:
  - bcd ← acc[4*DIGITOS-1:0].
  - estouro ← (acc digits 8..9 ≠ 0).
  - controle ← 1, ocupado ← 0, go to OCIOSO.
- Latency: results visible after E33; the next request can be accepted at E34 at the earliest.
- Requests asserted while ocupado = 1 get no ack; the requester keeps req high until ack.
- bcd, estouro and negativo change only in PUBLICA; they hold between conversions.
- Arithmetic: inputs are unsigned unless the feature is enabled.
  - 0xFFFFFFFF = 4294967295 gives bcd = 0x94967295, estouro = 1.

Optional Feature:
- Macro: SINAL_DISPLAY_EN.
- Defined:
  - The accepted word is two's complement; its magnitude (|x|, computed at acceptance) is converted.
  - negativo ← sign bit, latched in PUBLICA.
  - 0x80000000 gives magnitude 2147483648: bcd = 0x47483648, estouro = 1, negativo = 1.
- Not defined: input is unsigned; negativo is tied to 0.

Decomposition:
- Shared package display_pkg holds:
  - the state enum (OCIOSO, CONVERTE, PUBLICA);
  - N_BCD = 10;
  - CICLOS_CONV = 32;
  - the BCD digit-width constant (4).
- One natural sub-module: ajuste_bcd, a combinational single-digit add-3-if-≥5, instantiated N_BCD times inside the shift step.

Test Plan:
- Basic CPU request: after reset, req_cpu = 1, dado_cpu = 0x000004D2.
  - ack_cpu pulses one cycle; ocupado high for 33 cycles.
  - After E33: bcd = 0x00001234, controle = 1, estouro = 0.
- Simultaneous requests: req_cpu with 5 and req_dbg with 7 at the same edge.
  - CPU served first: bcd = 0x00000005, no ack_dbg.
  - Debug accepted at E34: bcd = 0x00000007.
- Boundaries, one request each:
  - 0x05F5E0FF → bcd = 0x99999999, estouro = 0.
  - 0x05F5E100 → bcd = 0x00000000, estouro = 1.
  - 0xFFFFFFFF → bcd = 0x94967295, estouro = 1.
- Reset mid-conversion: reset = 0 during CONVERTE cycle 10.
  - bcd, controle, ocupado and ack go to 0 immediately.
  - After release, req_cpu with 42 gives bcd = 0x00000042 with normal latency.
- Request during a conversion: req_dbg raised mid-CPU conversion.
  - No ack_dbg until OCIOSO.
  - ack_dbg exactly one cycle; displayed value = dado_dbg.
- Signed input, 0xFFFFFFFF:
  - With SINAL_DISPLAY_EN: bcd = 0x00000001, negativo = 1.
  - Without: bcd = 0x94967295, negativo = 0.
